// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_mem_pkg;

  // Arbiter states. The arbiter is either idle or serving exactly one port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_t;

  // Transfer size/sign codes (funct3 encoding).
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Instruction fetches are always full words.
  localparam logic [2:0] FETCH_TYPE = LW;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts cycles a granted access waits for its ack.
// Latency: expire is combinational once the count reaches TIMEOUT-1 while enabled.
// Backpressure: none; clr wins over en, the count holds at TIMEOUT-1.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       restart the count (asserted on each new grant)
//   en        count this cycle (access outstanding, no ack)
//   expire    the access has waited TIMEOUT cycles without an ack
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Gated by en so an ack arriving on the last cycle still wins.
  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port.
// Latency: request cycle 0 -> mem_req cycle 1 -> valid one cycle after mem_ack.
// Backpressure: requests hold until their valid pulse; x_stall tells the pipeline to wait.
//
// Ports:
//   CLK, Reset                         clock, asynchronous active-high reset
//   if_req/if_addr                     fetch request (held until if_valid)
//   if_rdata/if_valid/if_stall         fetch result, completion pulse, stall
//   d_rd_en/d_wr_en/d_addr/d_wdata/d_type   load/store request (held until d_valid)
//   d_rdata/d_valid/d_stall            load result (0 for stores), completion pulse, stall
//   err                                watchdog abort, coincident with the aborted port's valid
//   mem_req/mem_we/mem_addr/mem_wdata/mem_type   latched request to memory
//   mem_rdata/mem_ack                  memory response
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_rd_en,
  input  logic        d_wr_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] streak;
  logic          d_req;
  logic          arb_ok;
  logic          grant_if, grant_d;
  logic          done, abort;
  logic          wd_en, wd_expire;

  assign d_req = d_rd_en | d_wr_en;

  // While either valid is high its requester has not yet seen completion and
  // still presents the old request, so no arbitration happens that cycle.
  assign arb_ok = ~if_valid & ~d_valid;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  assign wd_en = (state != IDLE) & ~mem_ack;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (CLK),
    .rst    (Reset),
    .clr    (grant_if | grant_d),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_ok) begin
          // Data wins unless fetch has already lost MAX_D_STREAK times in a row.
          if (d_req && (!if_req || (streak < STREAK_MAX))) begin
            grant_d   = 1'b1;
            state_nxt = GNT_D;
          end else if (if_req) begin
            grant_if  = 1'b1;
            state_nxt = GNT_IF;
          end
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (wd_expire) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request registers and per-port results.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_wr_en;   // rd and wr together resolve to a write
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_type  <= d_type;
      end else if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_type  <= FETCH_TYPE;
      end else if (done || abort) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        err     <= abort;
        if (state == GNT_IF) begin
          if_valid <= 1'b1;
          if_rdata <= done ? mem_rdata : '0;
        end else begin
          d_valid <= 1'b1;
          d_rdata <= (done && !mem_we) ? mem_rdata : '0;
        end
      end
    end
  end

  // Consecutive data grants won against a waiting fetch.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      streak <= '0;
    end else if (!if_req || grant_if) begin
      streak <= '0;
    end else if (grant_d && (streak < STREAK_MAX)) begin
      streak <= streak + SW'(1);
    end
  end

endmodule
